// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and sizing helpers shared by the sync and async FIFO stages
package fifo_pkg;
   localparam int FIFO_DATA_W = 4;
   localparam int FIFO_DEPTH  = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 1) && ((n & (n - 1)) == 0);
   endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W register array, synchronous write, asynchronous read
module fifo_ram import fifo_pkg::*; #(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int DEPTH  = FIFO_DEPTH,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with thresholds, occupancy,
// overflow/underflow pulses, synchronous flush and optional FWFT read mode
module sync_fifo_param import fifo_pkg::*; #(
   parameter int DATA_W    = FIFO_DATA_W,
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter bit FWFT      = 1'b0,
   localparam int AW       = clog2(DEPTH),
   localparam int CW       = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CW-1:0]     count,
   output logic              overflow,
   output logic              underflow
);
   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
   end

   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d, rdata;
   logic              ovf_q, ovf_d, unf_q, unf_d, wr_ok, rd_ok;

   fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   // Flags decode only from the registered count, never from wr_en/rd_en.
   assign full         = count_q == FULL_C;
   assign empty        = count_q == '0;
   assign almost_full  = count_q >= AF_C;
   assign almost_empty = count_q <= AE_C;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign dout         = FWFT ? (empty ? '0 : rdata) : dout_q;

   always_comb begin
      wr_ok    = wr_en && !full && !flush;
      rd_ok    = rd_en && !empty && !flush;
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_ok);
      count_d  = flush ? '0 : count_q + CW'(wr_ok) - CW'(rd_ok);
      dout_d   = flush ? '0 : (rd_ok ? rdata : dout_q);
      ovf_d    = wr_en && full && !flush;
      unf_d    = rd_en && empty && !flush;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO that generalises the fixed 4x4 FIFO to any data width and power-of-two depth. Adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow pulses, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Used as the intra-domain buffer in front of, or behind, the async FIFO stage.

Parameters:
DATA_W, 4, data word width in bits (≥1)
DEPTH, 4, number of entries; power of two, ≥2
AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of FIFO contents
wr_en  in  1  write request
din  in  DATA_W  write data
rd_en  in  1  read request (acknowledge in FWFT mode)
dout  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count ≥ AF_THRESH
almost_empty  out  1  count ≤ AE_THRESH
count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write attempted while full
underflow  out  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset: asserting rst clears state immediately, independent of clk. Pointers = 0; count = 0; empty = 1; full = 0; almost_full = 0; almost_empty = 1; dout = 0; overflow = underflow = 0. Memory array is not reset.
- Reset mid-operation: all stored data is lost. The first edge after rst deasserts behaves as the post-reset state.
- Write accepted iff wr_en && !full && !flush. On accept, mem[wr_ptr] <= din and wr_ptr increments modulo DEPTH.
- Read accepted iff rd_en && !empty && !flush. On accept, rd_ptr increments modulo DEPTH.
- Full with simultaneous rd_en and wr_en: the read is accepted and the write is rejected (overflow pulses). Empty with both asserted: the write is accepted and the read is rejected (underflow pulses).
- Count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- All flags decode from the registered count. There is no combinational path from wr_en or rd_en to any flag.
- Flag latency: a write accepted at edge N makes empty deassert after edge N. A read accepted at edge N makes full deassert after edge N.
- FWFT=0: dout is registered. dout <= mem[rd_ptr] at the edge that accepts the read, so data appears one cycle after rd_en. dout holds its value at all other times, including on underflow.
- FWFT=1: dout = mem[rd_ptr] whenever empty = 0, and dout = 0 when empty = 1. rd_en pops the displayed word, and the next head appears after that edge.
- overflow/underflow: registered. High for exactly the one cycle following the edge at which the rejected request was sampled. Neither pulses while flush is high.
- flush: at the next edge, pointers and count = 0. wr_en and rd_en in that cycle are ignored. In FWFT=0 mode, dout is cleared to 0.
- Elaboration: DEPTH not a power of two, DEPTH < 2, or a threshold outside its legal range causes an elaboration-time error.

Decomposition:
- Shared package fifo_pkg holds the clog2 helper function and the default DATA_W/DEPTH constants shared with the async FIFO.
- One sub-module, fifo_ram: a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port.
- Pointer, count, flag and output logic stay in sync_fifo_param.

Test Plan:
1. Defaults (4x4, FWFT=0): write A,B,C,D on consecutive cycles -> almost_full=1 at count 3, full=1 at count 4. Then read 4 -> dout A,B,C,D, each one cycle after rd_en; empty=1 and almost_empty=1 at the end.
2. Full, then write E -> overflow high for 1 cycle, count stays 4. Draining yields A,B,C,D only. Read while empty -> underflow pulse, dout holds D, count 0.
3. Simultaneous ops: at count 2, rd+wr -> count stays 2 and order is preserved. At count 4, rd+wr -> count 3, read accepted, overflow pulse. At count 0, rd+wr -> count 1, underflow pulse.
4. DEPTH=8, DATA_W=8: 40 random-interleaved writes/reads of 0x00..0x27 -> output order exact across pointer wrap; count matches the model every cycle.
5. FWFT=1: write 0x5 into empty -> next cycle empty=0 and dout=0x5 with no rd_en. Pulse rd_en -> dout=0 and empty=1 on the following cycle.
6. flush at count 3 with wr_en=1 -> next cycle count=0, empty=1, no overflow. Assert rst asynchronously mid-write burst -> outputs reach reset values before the next clk edge.
